point_serializer: RTL and testbench
===================================

# point_serializer

Downstream stage of the scalar-multiply point generator. Captures the finished public-key point (`curve_point_t`, 256-bit x and y) when the generator asserts its done level. Emits it as a SEC1-encoded byte stream, MSB first, over a valid/ready handshake toward the host/UART/packet logic. Encodes the point at infinity, which the generator represents as (0,0), as the single SEC1 byte 0x00.

## Interface
- No parameters; byte width fixed at 8, coordinate width fixed at 256.
- clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_point  in  512 (curve_point_t)  point to encode; sampled only on the capture cycle
- in_valid  in  1  level from the generator's Done; may stay high indefinitely
- byte_ready  in  1  consumer can accept a byte this cycle
- byte_out  out  8  current byte; 0 when byte_valid low
- byte_valid  out  1  byte_out valid
- byte_last  out  1  high with the final byte of a frame (only while byte_valid)
- busy  out  1  high from capture through last-byte acceptance
- Done  out  1  one-cycle pulse the cycle after the last byte is accepted

## Operation
- States: Idle, Prefix, Body, Rearm.
- Idle:
  - When in_valid=1, capture x,y into a 512-bit shift register {x,y}.
  - Set flag inf = (x==0 && y==0).
  - Go to Prefix.
- Prefix: present the prefix byte with byte_valid=1.
  - inf: byte is 0x00, byte_last=1; on accept, go to Rearm.
  - Uncompressed: byte is 0x04.
  - Compressed: byte is 8'h02 | y[0].
  - Not inf, on accept: byte counter := 0, go to Body.
- Body:
  - byte_out = shift_reg[511:504].
  - On accept: shift left by 8; counter++.
  - byte_last=1 when counter == N-1, where N=64 (uncompressed) or N=32 (compressed: x only).
  - Accepting the last byte goes to Rearm.
- Rearm:
  - Done=1 for exactly this state's first cycle.
  - Remain until in_valid=0, then go to Idle. This prevents re-sending while the generator holds Done high.
- Transfer occurs only on byte_valid && byte_ready.
  - byte_out and byte_last are held stable while valid and not ready.
  - byte_valid is never dropped before acceptance.
- Byte counter: 7 bits. It never wraps within a frame; no value beyond N-1 is reachable.
- Changes on in_point after capture are ignored.

## Timing
- Reset values: byte_out=0, byte_valid=0, byte_last=0, busy=0, Done=0, state=Idle, shift register and counter cleared.
- Reset asserted mid-frame:
  - Frame is aborted; outputs take reset values on the next edge.
  - No Done pulse.
  - If in_valid is still high after reset release, a fresh frame is captured. Idle does not require a low first.
- Capture edge: in_valid=1 in Idle at edge k → byte_valid=1 with the prefix byte from cycle k+1.
- Throughput: 1 byte/cycle with byte_ready held high.
  - Uncompressed frame: 65 bytes in cycles k+1..k+65; Done in cycle k+66.
  - Compressed frame: 33 bytes; Done at k+34.
  - Infinity frame: 1 byte; Done at k+2.
- busy is high from k+1 through the cycle in which the last byte is accepted. It is low in the Done cycle.
- Rearm → Idle takes 1 cycle after in_valid is seen low. The earliest next capture is 1 cycle later.
- Simultaneous events: in_valid toggling during Prefix/Body has no effect.

## Configuration
- `POINT_COMPRESS_EN` defined:
  - SEC1 compressed format: prefix 0x02/0x03 from y parity, followed by 32 x bytes.
  - y bytes are not emitted.
  - The y half of the shift register may be reduced to bit 0.
- Undefined (default): uncompressed format, 0x04 then 32 x bytes then 32 y bytes.
- Infinity encoding (0x00) is identical in both builds.

## Test plan
- Uncompressed, byte_ready=1:
  - Stimulus: x bytes 0x01..0x20, y bytes 0x21..0x40, in_valid pulse.
  - Required: stream 0x04,0x01..0x40; byte_last only on the 65th byte; Done one cycle after it.
- Compressed build, same point (y[0]=0):
  - Required: 0x02,0x01..0x20; byte_last on the 33rd byte.
  - With y=…0x41 (odd), the prefix is 0x03.
- Backpressure:
  - Stimulus: byte_ready toggled with a random 50% pattern.
  - Required: the same byte sequence as with ready held high; byte_out/byte_last stable while stalled; no drops or duplicates.
- Infinity:
  - Stimulus: in_point=(0,0).
  - Required: single byte 0x00 with byte_last=1; Done at k+2.
- Held in_valid:
  - Stimulus: in_valid stays 1 for 200 cycles after the frame.
  - Required: exactly one frame; a second frame appears only after in_valid goes low then high.
- Reset mid-frame:
  - Stimulus: Reset asserted at byte 10.
  - Required: outputs zero next cycle, no Done; a fresh full frame after release if in_valid=1.

Source files
------------

// File: rtl/point_serializer.sv
// point_serializer: turns a finished curve point {x, y} into a SEC1 byte stream.
// The stream is sent MSB first over a valid/ready handshake.
// in_point layout: x in [511:256], y in [255:0].
// Build option: define POINT_COMPRESS_EN for the compressed form (0x02/0x03 + x).
// Without it, the uncompressed form is used (0x04 + x + y).
// The point at infinity, (0,0), is always sent as the single byte 0x00.
module point_serializer (
    input  logic         clk,
    input  logic         Reset,
    input  logic [511:0] in_point,
    input  logic         in_valid,
    input  logic         byte_ready,
    output logic [7:0]   byte_out,
    output logic         byte_valid,
    output logic         byte_last,
    output logic         busy,
    output logic         Done
);

`ifdef POINT_COMPRESS_EN
    // Only x is streamed; y contributes just its parity to the prefix.
    localparam int         SR_W     = 256;
    localparam logic [6:0] LAST_IDX = 7'd31;
`else
    localparam int         SR_W     = 512;
    localparam logic [6:0] LAST_IDX = 7'd63;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_BODY   = 2'd2,
        ST_REARM  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SR_W-1:0] shift_q, shift_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            inf_q, inf_d;
    logic            done_q, done_d;
    logic [7:0]      prefix_byte;
`ifdef POINT_COMPRESS_EN
    logic            ypar_q, ypar_d;
`endif

    // State, captured point and Done pulse register; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            inf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef POINT_COMPRESS_EN
            ypar_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            inf_q   <= inf_d;
            done_q  <= done_d;
`ifdef POINT_COMPRESS_EN
            ypar_q  <= ypar_d;
`endif
        end
    end

`ifdef POINT_COMPRESS_EN
    assign prefix_byte = {7'b0000001, ypar_q};
`else
    assign prefix_byte = 8'h04;
`endif

    // Next-state logic and handshake outputs; outputs decode the current state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        inf_d      = inf_q;
        done_d     = 1'b0;
`ifdef POINT_COMPRESS_EN
        ypar_d     = ypar_q;
`endif
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Capture does not wait for in_valid to be seen low first.
                if (in_valid) begin
                    shift_d = in_point[511 -: SR_W];
                    inf_d   = (in_point == 512'd0);
`ifdef POINT_COMPRESS_EN
                    ypar_d  = in_point[0];
`endif
                    cnt_d   = 7'd0;
                    state_d = ST_PREFIX;
                end
            end
            ST_PREFIX: begin
                byte_valid = 1'b1;
                busy       = 1'b1;
                byte_out   = inf_q ? 8'h00 : prefix_byte;
                byte_last  = inf_q;
                if (byte_ready) begin
                    if (inf_q) begin
                        state_d = ST_REARM;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = 7'd0;
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                byte_valid = 1'b1;
                busy       = 1'b1;
                byte_out   = shift_q[SR_W-1 -: 8];
                byte_last  = (cnt_q == LAST_IDX);
                if (byte_ready) begin
                    shift_d = shift_q << 8;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_REARM;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            ST_REARM: begin
                // Hold off until the generator drops its level so a point is sent once.
                if (!in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Done = done_q;

endmodule

// File: tb/tb_point_serializer.sv
// Testbench for point_serializer.
// A queue model builds the expected SEC1 byte stream from the point.
// The stream is captured at the handshake and compared against that model.
module tb_point_serializer;

    logic         clk = 1'b0;
    logic         Reset;
    logic [511:0] in_point;
    logic         in_valid;
    logic         byte_ready;
    logic [7:0]   byte_out;
    logic         byte_valid;
    logic         byte_last;
    logic         busy;
    logic         Done;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    localparam int LIMIT = 400;

    always #5 clk = ~clk;

    point_serializer dut (
        .clk        (clk),
        .Reset      (Reset),
        .in_point   (in_point),
        .in_valid   (in_valid),
        .byte_ready (byte_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .busy       (busy),
        .Done       (Done)
    );

    // Expected SEC1 encoding, computed from the coordinates with plain arithmetic.
    function automatic void build_expected(input logic [255:0] x, input logic [255:0] y);
        exp_q.delete();
        if (x == 256'd0 && y == 256'd0) begin
            exp_q.push_back(8'h00);
            return;
        end
`ifdef POINT_COMPRESS_EN
        exp_q.push_back(y[0] ? 8'h03 : 8'h02);
        for (int i = 0; i < 32; i++) exp_q.push_back(8'((x >> (8 * (31 - i))) & 256'hff));
`else
        exp_q.push_back(8'h04);
        for (int i = 0; i < 32; i++) exp_q.push_back(8'((x >> (8 * (31 - i))) & 256'hff));
        for (int i = 0; i < 32; i++) exp_q.push_back(8'((y >> (8 * (31 - i))) & 256'hff));
`endif
    endfunction

    // Number of positions where the captured stream differs from the model (length included).
    function automatic int count_diff();
        int d = 0;
        int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got_q.size() || i >= exp_q.size()) d++;
            else if (got_q[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    function automatic logic [255:0] rand_coord();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Runs one frame from the capture edge up to the Done pulse.
    // It records accepted bytes and protocol observations.
    // The caller has already raised in_valid at the preceding falling edge.
    task automatic collect(input bit rnd_ready, input bit drop_valid,
                           output int last_cnt, output int last_pos, output int done_t,
                           output int proto_err, output int busy_err);
        bit         stalled  = 1'b0;
        bit         finished = 1'b0;
        logic [7:0] pb = 8'h00;
        logic       pl = 1'b0;
        got_q.delete();
        last_cnt = 0; last_pos = -1; done_t = -1; proto_err = 0; busy_err = 0;
        for (int t = 1; t <= LIMIT && done_t < 0; t++) begin
            @(negedge clk);
            if (t == 1 && drop_valid) in_valid = 1'b0;
            if (Done) begin
                done_t = t;
                if (busy) busy_err++;
                if (!finished) proto_err++;
            end else if (!finished && !busy) begin
                busy_err++;
            end
            if (!byte_valid && byte_out !== 8'h00) proto_err++;
            if (!byte_valid && !finished) proto_err++;
            byte_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid) begin
                if (finished) proto_err++;
                if (stalled && (byte_out !== pb || byte_last !== pl)) proto_err++;
                if (byte_ready) begin
                    got_q.push_back(byte_out);
                    if (byte_last) begin
                        last_cnt++;
                        last_pos = got_q.size();
                        finished = 1'b1;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pb = byte_out;
                    pl = byte_last;
                end
            end
        end
        byte_ready = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_valid = 1'b0; byte_ready = 1'b1; in_point = '0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        chk_cnt++; if (byte_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", byte_valid); else pass_cnt++;
        chk_cnt++; if (byte_out !== 8'h00) $display("FAIL reset_byte got=%h want=00", byte_out); else pass_cnt++;
        chk_cnt++; if (byte_last !== 1'b0) $display("FAIL reset_last got=%b want=0", byte_last); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
        chk_cnt++; if (Done !== 1'b0) $display("FAIL reset_done got=%b want=0", Done); else pass_cnt++;
        $display("reset: outputs idle");
    endtask

    // Fixed pattern: x bytes 0x01..0x20, y bytes 0x21..0x40; a second run with an odd y.
    task automatic test_fixed_pattern();
        logic [255:0] x, y;
        int lc, lp, dt, pe, be;
        for (int i = 0; i < 32; i++) begin
            x[8*(31-i) +: 8] = 8'(i + 1);
            y[8*(31-i) +: 8] = 8'(i + 33);
        end
        for (int run = 0; run < 2; run++) begin
            if (run == 1) y[7:0] = 8'h41;
            build_expected(x, y);
            in_point = {x, y}; in_valid = 1'b1;
            collect(1'b0, 1'b1, lc, lp, dt, pe, be);
            chk_cnt++; if (count_diff() != 0) $display("FAIL fixed_bytes run=%0d got_len=%0d want_len=%0d first_got=%h first_want=%h", run, got_q.size(), exp_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]); else pass_cnt++;
            chk_cnt++; if (lc != 1 || lp != exp_q.size()) $display("FAIL fixed_last run=%0d got count=%0d pos=%0d want count=1 pos=%0d", run, lc, lp, exp_q.size()); else pass_cnt++;
            chk_cnt++; if (dt != exp_q.size() + 1) $display("FAIL fixed_done_cycle run=%0d got=%0d want=%0d", run, dt, exp_q.size() + 1); else pass_cnt++;
            chk_cnt++; if (pe != 0 || be != 0) $display("FAIL fixed_protocol run=%0d got proto=%0d busy=%0d want 0/0", run, pe, be); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (Done !== 1'b0) $display("FAIL fixed_done_width run=%0d got=%b want=0", run, Done); else pass_cnt++;
            $display("fixed run=%0d: %0d bytes, prefix=%h, done at k+%0d", run, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, dt);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] x, y;
        int lc, lp, dt, pe, be;
        for (int n = 0; n < 4; n++) begin
            x = rand_coord(); y = rand_coord();
            build_expected(x, y);
            in_point = {x, y}; in_valid = 1'b1;
            collect(1'b1, 1'b1, lc, lp, dt, pe, be);
            chk_cnt++; if (count_diff() != 0) $display("FAIL bp_bytes n=%0d got_len=%0d want_len=%0d diffs=%0d", n, got_q.size(), exp_q.size(), count_diff()); else pass_cnt++;
            chk_cnt++; if (lc != 1 || lp != exp_q.size()) $display("FAIL bp_last n=%0d got count=%0d pos=%0d want count=1 pos=%0d", n, lc, lp, exp_q.size()); else pass_cnt++;
            chk_cnt++; if (dt <= exp_q.size() || pe != 0 || be != 0) $display("FAIL bp_protocol n=%0d got done=%0d proto=%0d busy=%0d want done>%0d 0 0", n, dt, pe, be, exp_q.size()); else pass_cnt++;
            @(negedge clk);
            $display("backpressure n=%0d: %0d bytes, done at k+%0d", n, got_q.size(), dt);
        end
    endtask

    task automatic test_infinity();
        int lc, lp, dt, pe, be;
        build_expected(256'd0, 256'd0);
        in_point = '0; in_valid = 1'b1;
        collect(1'b0, 1'b1, lc, lp, dt, pe, be);
        chk_cnt++; if (got_q.size() != 1 || got_q[0] !== 8'h00) $display("FAIL inf_bytes got_len=%0d want single 00", got_q.size()); else pass_cnt++;
        chk_cnt++; if (lc != 1 || lp != 1) $display("FAIL inf_last got count=%0d pos=%0d want 1/1", lc, lp); else pass_cnt++;
        chk_cnt++; if (dt != 2) $display("FAIL inf_done_cycle got=%0d want=2", dt); else pass_cnt++;
        chk_cnt++; if (pe != 0 || be != 0) $display("FAIL inf_protocol got proto=%0d busy=%0d want 0/0", pe, be); else pass_cnt++;
        @(negedge clk);
        $display("infinity: %0d byte, done at k+%0d", got_q.size(), dt);
    endtask

    task automatic test_held_valid();
        logic [255:0] x, y;
        int lc, lp, dt, pe, be;
        int extra = 0;
        x = rand_coord(); y = rand_coord();
        build_expected(x, y);
        in_point = {x, y}; in_valid = 1'b1;
        collect(1'b0, 1'b0, lc, lp, dt, pe, be);
        chk_cnt++; if (count_diff() != 0 || dt != exp_q.size() + 1) $display("FAIL held_first_frame got_len=%0d done=%0d want_len=%0d done=%0d", got_q.size(), dt, exp_q.size(), exp_q.size() + 1); else pass_cnt++;
        in_point = {rand_coord(), rand_coord()};
        repeat (200) begin
            @(negedge clk);
            if (byte_valid || Done || busy) extra++;
        end
        chk_cnt++; if (extra != 0) $display("FAIL held_no_resend got=%0d active cycles want=0", extra); else pass_cnt++;
        in_valid = 1'b0;
        @(negedge clk);
        x = rand_coord(); y = rand_coord();
        build_expected(x, y);
        in_point = {x, y}; in_valid = 1'b1;
        collect(1'b0, 1'b1, lc, lp, dt, pe, be);
        chk_cnt++; if (count_diff() != 0 || lc != 1 || dt != exp_q.size() + 1) $display("FAIL held_second_frame got_len=%0d last=%0d done=%0d want_len=%0d last=1 done=%0d", got_q.size(), lc, dt, exp_q.size(), exp_q.size() + 1); else pass_cnt++;
        @(negedge clk);
        $display("held valid: second frame %0d bytes after re-arm", got_q.size());
    endtask

    task automatic test_reset_mid_frame();
        logic [255:0] x, y;
        int lc, lp, dt, pe, be;
        int early = 0;
        x = rand_coord(); y = rand_coord();
        build_expected(x, y);
        in_point = {x, y}; in_valid = 1'b1; byte_ready = 1'b1;
        got_q.delete();
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (byte_valid) got_q.push_back(byte_out);
            if (Done) early++;
        end
        chk_cnt++; if (got_q.size() != 10 || got_q[9] !== exp_q[9] || early != 0) $display("FAIL rst_partial got_len=%0d byte9=%h done=%0d want_len=10 byte9=%h done=0", got_q.size(), (got_q.size() > 9) ? got_q[9] : 8'hxx, early, exp_q[9]); else pass_cnt++;
        Reset = 1'b1;
        @(negedge clk);
        chk_cnt++; if (byte_valid !== 1'b0 || byte_out !== 8'h00 || byte_last !== 1'b0 || busy !== 1'b0) $display("FAIL rst_outputs got v=%b b=%h l=%b busy=%b want 0 00 0 0", byte_valid, byte_out, byte_last, busy); else pass_cnt++;
        chk_cnt++; if (Done !== 1'b0) $display("FAIL rst_no_done got=%b want=0", Done); else pass_cnt++;
        Reset = 1'b0;
        collect(1'b0, 1'b1, lc, lp, dt, pe, be);
        chk_cnt++; if (count_diff() != 0 || lc != 1 || dt != exp_q.size() + 1 || pe != 0) $display("FAIL rst_fresh_frame got_len=%0d last=%0d done=%0d proto=%0d want_len=%0d last=1 done=%0d proto=0", got_q.size(), lc, dt, pe, exp_q.size(), exp_q.size() + 1); else pass_cnt++;
        @(negedge clk);
        $display("reset mid-frame: fresh frame %0d bytes, done at k+%0d", got_q.size(), dt);
    endtask

    initial begin
        test_reset();
        test_fixed_pattern();
        test_backpressure();
        test_infinity();
        test_held_valid();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
